// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like bus responder: size codes,
// the queued request entry, and the LFSR used by the optional random-delay mode.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [29:0] idx;
    logic [31:0] wdata;
  } req_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order queue of accepted requests; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module sram_like_req_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  req_entry_t               din,
  input  logic                     pop,
  output req_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  req_entry_t    buffer [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) buffer[wptr] <= din;
  end

  assign head = buffer[rptr];

endmodule

// File: rtl/sram_like_resp.sv
// Responder end of the sram-like bus: accepts requests, answers them in order after RESP_LAT cycles.
// Define SRAM_LIKE_RAND_DELAY_EN to add LFSR-driven acceptance gaps and extra response latency.
module sram_like_resp
  import sram_like_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DLY_W = 5;
  localparam logic [DLY_W-1:0] LAT_M1 = DLY_W'(RESP_LAT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic             run;
  logic             gate;
  logic [2:0]       extra;
  logic             push;
  logic             fire;
  logic [0:0]       state;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] load;
  logic [CNT_W-1:0] count;
  req_entry_t       din;
  req_entry_t       head;
  logic [AW-1:0]    widx;
  logic [31:0]      mem [2**AW];
  logic             unused_ok;

  // Acceptance is held off for the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

`ifdef SRAM_LIKE_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_next(lfsr);
  end

  assign gate  = lfsr[0];
  assign extra = lfsr[3:1];
`else
  assign gate  = 1'b0;
  assign extra = 3'd0;
`endif

  // Only the registered count decides space; a same-cycle pop does not free a slot.
  assign addr_ok = run && (count < CNT_W'(DEPTH)) && !gate;
  assign push    = req && addr_ok;

  always_comb begin
    din       = '0;
    din.wr    = wr;
    din.size  = size;
    din.wstrb = wstrb;
    din.idx   = 30'(addr[AW+1:2]);
    din.wdata = wdata;
  end

  sram_like_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (din),
    .pop    (fire),
    .head   (head),
    .count  (count)
  );

  assign widx = head.idx[AW-1:0];
  assign load = LAT_M1 + {2'b00, extra};

  // The response fires in the cycle the head's countdown is exhausted; from IDLE
  // that can be the very first cycle the head is visible when the load is zero.
  assign fire = (count != '0) &&
                (((state == ST_IDLE) && (load == '0)) ||
                 ((state == ST_WAIT) && (cnt == '0)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (fire) begin
      if (count > CNT_W'(1)) begin
        state <= ST_WAIT;
        cnt   <= load;
      end else begin
        state <= ST_IDLE;
      end
    end else if ((state == ST_IDLE) && (count != '0)) begin
      state <= ST_WAIT;
      cnt   <= load - 1'b1;
    end else if (state == ST_WAIT) begin
      cnt   <= cnt - 1'b1;
    end
  end

  // Writes land at response time so later queued reads see them.
  always_ff @(posedge clk) begin
    if (fire && head.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head.wstrb[i]) mem[widx][8*i +: 8] <= head.wdata[8*i +: 8];
      end
    end
  end

  assign data_ok = fire;
  assign rdata   = (fire && !head.wr) ? mem[widx] : 32'd0;

  assign unused_ok = ^{addr[31:AW+2], addr[1:0], head.size, head.idx[29:AW]};

endmodule

// File: tb/tb_sram_like_resp.sv
// Scoreboard bench for sram_like_resp: random and directed traffic against a
// queue-plus-memory reference model, with a negedge monitor doing all checks.
module tb_sram_like_resp;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_resp #(.AW(AW), .DEPTH(DEPTH), .RESP_LAT(LAT)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  typedef struct {
    bit          wr;
    int unsigned idx;
    bit [3:0]    wstrb;
    bit [31:0]   wdata;
    longint      due;
    bit          chk;
    bit [31:0]   exp;
  } txn_t;

  txn_t        q[$];
  bit [31:0]   mm [int unsigned];
  longint      cyc = 0;
  longint      last_due = 0;
  bit          run_exp = 1'b0;
  bit          last_acc = 1'b0;
  int          n_acc = 0;
  int          n_resp = 0;
  bit          chk_en = 1'b0;
  bit [31:0]   chk_val = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) run_exp <= 1'b0;
    else         run_exp <= 1'b1;
  end

  // Monitor: space check, response check/pop, then record this cycle's acceptance.
  always @(negedge clk) begin
    bit        exp_ok;
    txn_t      t;
    txn_t      n;
    bit [31:0] w;
    exp_ok = run_exp && (q.size() < DEPTH);
`ifdef SRAM_LIKE_RAND_DELAY_EN
    if (!exp_ok) chk("addr_ok_blocked", {31'd0, addr_ok}, 32'd0);
`else
    chk("addr_ok", {31'd0, addr_ok}, {31'd0, exp_ok});
`endif
    if (data_ok) begin
      if (q.size() == 0) begin
        chk("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        t = q.pop_front();
        n_resp++;
`ifdef SRAM_LIKE_RAND_DELAY_EN
        chk("resp_not_early", {31'd0, (cyc >= t.due)}, 32'd1);
`else
        chk("resp_cycle", 32'(cyc), 32'(t.due));
`endif
        w = mm.exists(t.idx) ? mm[t.idx] : 32'd0;
        if (t.wr) begin
          chk("rdata_on_write", rdata, 32'd0);
          for (int i = 0; i < 4; i++)
            if (t.wstrb[i]) w[8*i +: 8] = t.wdata[8*i +: 8];
          mm[t.idx] = w;
        end else begin
          if (mm.exists(t.idx)) chk("read_data", rdata, w);
          if (t.chk) chk("directed_read", rdata, t.exp);
        end
      end
    end else begin
      chk("rdata_idle", rdata, 32'd0);
    end
    last_acc = req && addr_ok;
    if (last_acc) begin
      n.wr    = wr;
      n.idx   = int'(addr[AW+1:2]);
      n.wstrb = wstrb;
      n.wdata = wdata;
      n.due   = ((cyc > last_due) ? cyc : last_due) + LAT;
      n.chk   = chk_en;
      n.exp   = chk_val;
      last_due = n.due;
      q.push_back(n);
      n_acc++;
    end
  end

  task automatic issue(input bit w, input bit [31:0] a, input bit [1:0] s, input bit [3:0] st,
                       input bit [31:0] d, input bit c, input bit [31:0] e);
    int tries;
    tries = 0;
    req = 1'b1; wr = w; addr = a; size = s; wstrb = st; wdata = d; chk_en = c; chk_val = e;
    do begin
      @(posedge clk);
      tries++;
    end while (!last_acc && tries < 400);
    if (!last_acc) chk("issue_timeout", 32'd1, 32'd0);
    #1;
    req = 1'b0; wr = 1'($urandom); addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    chk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (q.size() != 0 && tries < 600) begin
      @(posedge clk);
      tries++;
    end
    #1;
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit        w;
    int        ix;
    int        gap;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("reset_data_ok", {31'd0, data_ok}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    resetn = 1'b1;
    #1;
    chk("addr_ok_before_first_edge", {31'd0, addr_ok}, 32'd0);
    idle(1);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 2'd2, 4'hF, $urandom, 1'b0, 32'd0);
    drain();

    issue(1'b1, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 2'd2, 4'h0, 32'd0, 1'b1, 32'hDEADBEEF);
    drain();

    issue(1'b1, 32'h11, 2'd0, 4'b0010, 32'h0000AA00, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 2'd2, 4'h0, 32'd0, 1'b1, 32'hDEADAAEF);
    drain();

    issue(1'b1, 32'h20, 2'd2, 4'hF, 32'h1, 1'b0, 32'd0);
    issue(1'b0, 32'h20, 2'd2, 4'h0, 32'd0, 1'b1, 32'h1);
    drain();

    for (int i = 0; i < 8; i++) issue(1'b0, 32'($urandom_range(0, 15) * 4), 2'd2, 4'h0, 32'd0, 1'b0, 32'd0);
    drain();
    chk("accepts_eq_responses", 32'(n_acc), 32'(n_resp));

    issue(1'b1, 32'h30, 2'd2, 4'hF, 32'h12345678, 1'b0, 32'd0);
    drain();
    issue(1'b1, 32'h30, 2'd2, 4'hF, 32'hBAD0BAD0, 1'b0, 32'd0);
    issue(1'b0, 32'h30, 2'd2, 4'h0, 32'd0, 1'b0, 32'd0);
    issue(1'b0, 32'h30, 2'd2, 4'h0, 32'd0, 1'b0, 32'd0);
    #2;
    resetn = 1'b0;
    n_acc = n_acc - q.size();
    q.delete();
    last_due = 0;
    #1;
    chk("midreset_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("midreset_data_ok", {31'd0, data_ok}, 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle(8);
    issue(1'b0, 32'h30, 2'd2, 4'h0, 32'd0, 1'b1, 32'h12345678);
    drain();

`ifdef SRAM_LIKE_RAND_DELAY_EN
    for (int k = 0; k < 1000; k++) begin
`else
    for (int k = 0; k < 400; k++) begin
`endif
      gap = $urandom_range(0, 3);
      if (gap > 1) idle(gap - 1);
      w  = 1'($urandom_range(0, 1));
      ix = $urandom_range(0, 15);
      issue(w, 32'(ix * 4 + $urandom_range(0, 3)), 2'($urandom), 4'($urandom), $urandom, 1'b0, 32'd0);
    end
    drain();
    idle(20);
    chk("final_accepts_eq_responses", 32'(n_acc), 32'(n_resp));
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
